// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared widths, iteration count and FSM state encoding for multdiv_32
package multdiv_pkg;
  localparam int WIDTH = 32;
  localparam int ITERS = 32;
  localparam int CNT_W = 6;
  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_e;
endpackage

// File: rtl/booth_step_32.sv
// booth_step_32: one radix-2 Booth iteration (add/sub + arithmetic right shift) on {acc, Q, q-1}
//   r_i : current 65-bit {acc[31:0], Q[31:0], q-1}
//   m_i : multiplicand
//   r_o : register after one add/sub and 1-bit arithmetic shift
module booth_step_32
  import multdiv_pkg::*;
(
  input  logic [2*WIDTH:0]  r_i,
  input  logic [WIDTH-1:0]  m_i,
  output logic [2*WIDTH:0]  r_o
);
  logic [WIDTH:0] acc_x, m_x, sum;
  // The sum is kept one bit wider so subtracting the most negative multiplicand
  // cannot overflow; the shift then folds that extra bit back into the register.
  assign acc_x = {r_i[2*WIDTH], r_i[2*WIDTH:WIDTH+1]};
  assign m_x   = {m_i[WIDTH-1], m_i};
  always_comb
    sum = (r_i[1:0] == 2'b01) ? acc_x + m_x :
          (r_i[1:0] == 2'b10) ? acc_x - m_x : acc_x;
  assign r_o = {sum, r_i[WIDTH:1]};
endmodule

// File: rtl/multdiv_32.sv
// multdiv_32: multi-cycle signed 32-bit Booth multiply / restoring divide with registered result
//   clock, reset (async active-low)
//   data_operandA/B : operands latched on a start strobe
//   ctrl_MULT/DIV   : one-cycle start strobes (both high selects multiply)
//   data_result, data_exception : registered result and overflow / divide-by-zero flag
//   data_resultRDY  : one-cycle pulse when a result completes
module multdiv_32
  import multdiv_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH:0]   acc_q, acc_d, booth_r, div_r;
  logic [WIDTH-1:0]   m_q, m_d, res_q, res_d, a_mag, b_mag, quo, div_res;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     diff;
  logic               neg_q, neg_d, div0_q, div0_d, ovf_q, ovf_d, exc_q, exc_d;
  logic               start, take, mul_exc;

  booth_step_32 u_booth (.r_i(acc_q), .m_i(m_q), .r_o(booth_r));

  assign start = ctrl_MULT | ctrl_DIV;
  assign a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  // Divide reuses the 65-bit register as {R[31:0], Q[31:0], unused}; {R, Q[31]} is the shifted partial remainder.
  assign diff  = acc_q[2*WIDTH:WIDTH] - {1'b0, m_q};
  assign take  = ~diff[WIDTH];
  assign div_r = {take ? diff[WIDTH-1:0] : acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1:1], take, 1'b0};
  assign prod    = acc_q[2*WIDTH:1];
  assign mul_exc = prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
  assign quo     = acc_q[WIDTH:1];
  assign div_res = div0_q ? '0 : neg_q ? -quo : quo;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    m_d     = m_q;
    neg_d   = neg_q;
    div0_d  = div0_q;
    ovf_d   = ovf_q;
    res_d   = res_q;
    exc_d   = exc_q;
    if (start) begin
      state_d = ctrl_MULT ? MULT : DIV;
      cnt_d   = '0;
      acc_d   = {{WIDTH{1'b0}}, ctrl_MULT ? data_operandB : a_mag, 1'b0};
      m_d     = ctrl_MULT ? data_operandA : b_mag;
      neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      div0_d  = data_operandB == '0;
      ovf_d   = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1);
    end else begin
      case (state_q)
        MULT, DIV: begin
          if (cnt_q == CNT_W'(ITERS)) begin
            state_d = DONE;
            res_d   = state_q == MULT ? prod[WIDTH-1:0] : div_res;
            exc_d   = state_q == MULT ? mul_exc : (div0_q | ovf_q);
          end else begin
            cnt_d = cnt_q + 1'b1;
            acc_d = state_q == MULT ? booth_r : div_r;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      neg_q   <= 1'b0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
      res_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      neg_q   <= neg_d;
      div0_q  <= div0_d;
      ovf_q   <= ovf_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
    end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = state_q == DONE;
endmodule

// File: tb/tb_multdiv_32.sv
// tb_multdiv_32: scoreboard bench for multdiv_32
module tb_multdiv_32;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_operandA, data_operandB, data_result;
  logic        ctrl_MULT, ctrl_DIV, data_exception, data_resultRDY;

  typedef struct { logic [31:0] res; logic exc; int cyc; } exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0, cyc = 0, rdy_cnt = 0;
  logic prev_rdy = 1'b0;

  multdiv_32 dut (
    .clock(clock), .reset(reset),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (data_resultRDY) begin
      exp_t e;
      rdy_cnt++;
      chk("pulse_width", 64'(prev_rdy), 0);
      if (sb.size() == 0) chk("spurious_rdy", 64'(data_resultRDY), 0);
      else begin
        e = sb.pop_front();
        chk("result", 64'(data_result), 64'(e.res));
        chk("exception", 64'(data_exception), 64'(e.exc));
        chk("latency", 64'(cyc), 64'(e.cyc));
      end
    end
    prev_rdy = data_resultRDY;
  end

  function automatic exp_t model(input bit is_div, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint p;
    int q;
    if (!is_div) begin
      p = longint'($signed(a)) * longint'($signed(b));
      e.res = p[31:0];
      e.exc = p != longint'($signed(e.res));
    end else if (b == 0) begin
      e.res = 0; e.exc = 1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.res = 32'h8000_0000; e.exc = 1;
    end else begin
      q = $signed(a) / $signed(b);
      e.res = q; e.exc = 0;
    end
    return e;
  endfunction

  // Called at a negedge; the strobe is sampled on the following posedge (E0).
  task automatic start_op(input bit is_div, input logic [31:0] a, input logic [31:0] b, input bit keep);
    exp_t e;
    e = model(is_div, a, b);
    e.cyc = cyc + 1 + 33;
    if (!keep) sb.delete();
    sb.push_back(e);
    data_operandA = a; data_operandB = b;
    ctrl_MULT = !is_div; ctrl_DIV = is_div;
    @(negedge clock);
    ctrl_MULT = 0; ctrl_DIV = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clock);
    chk("drain_timeout", 64'(sb.size()), 0);
    @(negedge clock);
  endtask

  task automatic run(input bit is_div, input logic [31:0] a, input logic [31:0] b);
    start_op(is_div, a, b, 0);
    drain();
  endtask

  initial begin
    int saved;
    reset = 0; ctrl_MULT = 0; ctrl_DIV = 0; data_operandA = 0; data_operandB = 0;
    repeat (3) @(negedge clock);
    chk("rst_result", 64'(data_result), 0);
    chk("rst_exc", 64'(data_exception), 0);
    chk("rst_rdy", 64'(data_resultRDY), 0);
    reset = 1;
    @(negedge clock);
    run(0, 7, 32'hFFFF_FFFD);
    run(0, 32'h0001_0000, 32'h0001_0000);
    run(0, 32'h8000_0000, 32'hFFFF_FFFF);
    run(0, 32'h8000_0000, 32'h8000_0000);
    run(1, 32'hFFFF_FFF9, 2);
    run(1, 100, 7);
    run(1, 5, 0);
    run(1, 32'h8000_0000, 32'hFFFF_FFFF);
    run(1, 32'h8000_0000, 1);
    for (int i = 0; i < 6; i++) begin
      run(0, $urandom, (i < 3) ? 32'($urandom_range(0, 65535)) : $urandom);
      run(1, $urandom, (i < 3) ? 32'($urandom_range(1, 255)) : $urandom);
    end
    // restart: multiply aborted by a divide nine cycles later
    saved = rdy_cnt;
    start_op(0, 3, 4, 0);
    repeat (8) @(negedge clock);
    start_op(1, 20, 5, 0);
    drain();
    repeat (40) @(negedge clock);
    chk("restart_pulses", 64'(rdy_cnt - saved), 1);
    // back-to-back: new strobe while ready is high
    start_op(0, 6, 7, 0);
    for (int i = 0; i < 40 && !data_resultRDY; i++) @(negedge clock);
    start_op(1, 1000, 32'hFFFF_FFF6, 1);
    drain();
    // reset mid-multiply (previous result is nonzero)
    start_op(0, 11, 13, 0);
    repeat (14) @(negedge clock);
    reset = 0;
    #1;
    chk("midrst_result", 64'(data_result), 0);
    chk("midrst_exc", 64'(data_exception), 0);
    chk("midrst_rdy", 64'(data_resultRDY), 0);
    sb.delete();
    saved = rdy_cnt;
    @(negedge clock);
    reset = 1;
    repeat (100) @(negedge clock);
    chk("no_rdy_after_reset", 64'(rdy_cnt - saved), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
